// File: rtl/conv_vect_feeder.sv
// Serial replay source for the convolution vector engine: buffers up to two pixel
// vectors and streams each element REPEAT times with line/frame framing flags.
module conv_vect_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int VECT_LEN   = 8,
    parameter int REPEAT     = 3,
    parameter int STRING_LEN = 224,
    parameter int STRING_NUM = 224
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [VECT_LEN*DATA_WIDTH-1:0] vect_i,
    input  logic                           vect_valid_i,
    input  logic                           vect_sof_i,
    output logic                           vect_ready_o,
    output logic signed [DATA_WIDTH-1:0]   data_o,
    output logic                           valid_o,
    output logic                           sop_o,
    output logic                           eop_o,
    output logic                           sof_o,
    output logic                           eof_o,
    output logic                           busy_o
);

    localparam int REP_W  = $clog2(REPEAT) + 1;
    localparam int ELEM_W = $clog2(VECT_LEN) + 1;
    localparam int COL_W  = $clog2(STRING_LEN) + 1;
    localparam int ROW_W  = $clog2(STRING_NUM) + 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                         state;
    logic [VECT_LEN*DATA_WIDTH-1:0] buf_vect [2];
    logic [1:0]                     buf_sof;
    logic                           wr_ptr, rd_ptr;
    logic [1:0]                     count, count_next;
    logic [REP_W-1:0]               rep_cnt;
    logic [ELEM_W-1:0]              elem_cnt;
    logic [COL_W-1:0]               col, eff_col;
    logic [ROW_W-1:0]               row, eff_row;
    logic                           accept, emit, first, last;
    logic                           rep_last, elem_last, col_last, row_last;
    logic [VECT_LEN*DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0]          sample;

    always_comb begin
        vect_ready_o = (count < 2'd2);
        accept       = vect_valid_i & vect_ready_o;
        emit         = (count != 2'd0);
        head         = buf_vect[rd_ptr];
        rep_last     = (rep_cnt == REP_W'(REPEAT - 1));
        elem_last    = (elem_cnt == ELEM_W'(VECT_LEN - 1));
        first        = emit && (rep_cnt == '0) && (elem_cnt == '0);
        last         = emit && rep_last && elem_last;
        // A sof-flagged head pixel is positioned at the frame origin for its whole duration.
        eff_col      = buf_sof[rd_ptr] ? '0 : col;
        eff_row      = buf_sof[rd_ptr] ? '0 : row;
        col_last     = (eff_col == COL_W'(STRING_LEN - 1));
        row_last     = (eff_row == ROW_W'(STRING_NUM - 1));
        count_next   = count + {1'b0, accept} - {1'b0, last};
        busy_o       = emit | (state == STREAM);
        sample       = '0;
        for (int unsigned m = 0; m < VECT_LEN; m++) begin
            if (elem_cnt == ELEM_W'(m)) begin
                sample = head[m*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            buf_vect[0] <= '0;
            buf_vect[1] <= '0;
            buf_sof     <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            rep_cnt     <= '0;
            elem_cnt    <= '0;
            col         <= '0;
            row         <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            sop_o       <= 1'b0;
            eop_o       <= 1'b0;
            sof_o       <= 1'b0;
            eof_o       <= 1'b0;
        end else begin
            if (accept) begin
                buf_vect[wr_ptr] <= vect_i;
                buf_sof[wr_ptr]  <= vect_sof_i;
                wr_ptr           <= ~wr_ptr;
            end
            count   <= count_next;
            // STREAM marks cycles presenting a sample; IDLE is entered once nothing is left.
            state   <= emit ? STREAM : IDLE;
            valid_o <= emit;
            sop_o   <= first && (eff_col == '0);
            sof_o   <= first && (eff_col == '0) && (eff_row == '0);
            eop_o   <= last && col_last;
            eof_o   <= last && col_last && row_last;
            if (emit) begin
                data_o <= sample;
                if (rep_last) begin
                    rep_cnt  <= '0;
                    elem_cnt <= elem_last ? '0 : elem_cnt + ELEM_W'(1);
                end else begin
                    rep_cnt <= rep_cnt + REP_W'(1);
                end
            end
            if (last) begin
                rd_ptr <= ~rd_ptr;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : eff_row + ROW_W'(1);
                end else begin
                    col <= eff_col + COL_W'(1);
                    row <= eff_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_vect_feeder.sv
// Scoreboard bench for conv_vect_feeder: a small-geometry instance (A) and a
// degenerate one-sample-per-pixel instance (B), both checked against a pixel-level model.
module tb_conv_vect_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]       a_vect;
    logic              a_valid, a_sofi, a_ready, a_vo, a_sop, a_eop, a_sof, a_eof, a_busy;
    logic signed [7:0] a_data;
    logic [7:0]        b_vect;
    logic              b_valid, b_sofi, b_ready, b_vo, b_sop, b_eop, b_sof, b_eof, b_busy;
    logic signed [7:0] b_data;

    conv_vect_feeder #(.DATA_WIDTH(8), .VECT_LEN(4), .REPEAT(3), .STRING_LEN(2), .STRING_NUM(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .vect_i(a_vect), .vect_valid_i(a_valid), .vect_sof_i(a_sofi),
        .vect_ready_o(a_ready), .data_o(a_data), .valid_o(a_vo), .sop_o(a_sop), .eop_o(a_eop),
        .sof_o(a_sof), .eof_o(a_eof), .busy_o(a_busy));

    conv_vect_feeder #(.DATA_WIDTH(8), .VECT_LEN(1), .REPEAT(1), .STRING_LEN(1), .STRING_NUM(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .vect_i(b_vect), .vect_valid_i(b_valid), .vect_sof_i(b_sofi),
        .vect_ready_o(b_ready), .data_o(b_data), .valid_o(b_vo), .sop_o(b_sop), .eop_o(b_eop),
        .sof_o(b_sof), .eof_o(b_eof), .busy_o(b_busy));

    localparam int VL [2] = '{4, 1};
    localparam int RP [2] = '{3, 1};
    localparam int SL [2] = '{2, 1};
    localparam int SN [2] = '{2, 1};

    typedef struct {
        logic [7:0] data;
        logic [3:0] fl;   // {sop, eop, sof, eof}
        int         cyc;
    } exp_t;
    typedef struct {
        int acc;
        int fin;
    } pix_t;

    exp_t sb [2][$];
    pix_t pq [2][$];
    int   colm [2];
    int   rowm [2];
    int   last_end [2];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Pixel accepted at the coming edge: schedule its samples behind anything still queued.
    task automatic record(input int w, input logic [31:0] vec, input logic s);
        int   acc, start, n;
        exp_t e;
        acc   = cyc + 1;
        n     = VL[w] * RP[w];
        start = (acc + 1 > last_end[w] + 1) ? acc + 1 : last_end[w] + 1;
        if (s) begin
            colm[w] = 0;
            rowm[w] = 0;
        end
        for (int i = 0; i < n; i++) begin
            e.data = vec[(i / RP[w]) * 8 +: 8];
            e.fl[3] = (i == 0) && (colm[w] == 0);
            e.fl[2] = (i == n - 1) && (colm[w] == SL[w] - 1);
            e.fl[1] = e.fl[3] && (rowm[w] == 0);
            e.fl[0] = e.fl[2] && (rowm[w] == SN[w] - 1);
            e.cyc  = start + i;
            sb[w].push_back(e);
        end
        last_end[w] = start + n - 1;
        pq[w].push_back('{acc: acc, fin: last_end[w]});
        colm[w]++;
        if (colm[w] == SL[w]) begin
            colm[w] = 0;
            rowm[w] = (rowm[w] == SN[w] - 1) ? 0 : rowm[w] + 1;
        end
    endtask

    task automatic flush();
        for (int w = 0; w < 2; w++) begin
            sb[w].delete();
            pq[w].delete();
            colm[w]     = 0;
            rowm[w]     = 0;
            last_end[w] = 0;
        end
    endtask

    task automatic mon(input int w, input logic v, input logic [7:0] d, input logic [3:0] fl,
                       input logic rdy, input logic bsy);
        int   occ;
        logic vexp;
        exp_t e;
        occ  = 0;
        vexp = 1'b0;
        while (pq[w].size() > 0 && pq[w][0].fin <= cyc) void'(pq[w].pop_front());
        for (int i = 0; i < pq[w].size(); i++) if (pq[w][i].acc <= cyc) occ++;
        if (sb[w].size() > 0) vexp = (sb[w][0].cyc == cyc);
        chk($sformatf("dut%0d_ready", w), {31'd0, rdy}, {31'd0, occ < 2});
        chk($sformatf("dut%0d_busy", w), {31'd0, bsy}, {31'd0, (occ > 0) || vexp});
        chk($sformatf("dut%0d_valid", w), {31'd0, v}, {31'd0, vexp});
        if (v && sb[w].size() > 0) begin
            e = sb[w].pop_front();
            chk($sformatf("dut%0d_sample_cycle", w), cyc, e.cyc);
            chk($sformatf("dut%0d_data_flags", w), {20'd0, d, fl}, {20'd0, e.data, e.fl});
        end else if (!v) begin
            chk($sformatf("dut%0d_idle_flags", w), {28'd0, fl}, 32'd0);
        end
    endtask

    always @(negedge clk) if (reset_n) mon(0, a_vo, a_data, {a_sop, a_eop, a_sof, a_eof}, a_ready, a_busy);
    always @(negedge clk) if (reset_n) mon(1, b_vo, b_data, {b_sop, b_eop, b_sof, b_eof}, b_ready, b_busy);

    task automatic drive(input int w, input logic [31:0] vec, input logic s, input logic v);
        if (w == 0) begin
            a_vect = vec; a_sofi = s; a_valid = v;
        end else begin
            b_vect = vec[7:0]; b_sofi = s; b_valid = v;
        end
    endtask

    // Called at a negedge; holds the offer until accepted, returns at the negedge after transfer.
    task automatic send(input int w, input logic [31:0] vec, input logic s);
        int guard;
        guard = 0;
        drive(w, vec, s, 1'b1);
        while (((w == 0) ? !a_ready : !b_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) timeout_fail("accept");
        else record(w, vec, s);
        @(negedge clk);
        drive(w, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((sb[0].size() > 0 || sb[1].size() > 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) timeout_fail("drain");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state();
        chk("rst_valid_a", {31'd0, a_vo}, 32'd0);
        chk("rst_flags_a", {28'd0, a_sop, a_eop, a_sof, a_eof}, 32'd0);
        chk("rst_data_a", {24'd0, a_data}, 32'd0);
        chk("rst_ready_a", {31'd0, a_ready}, 32'd1);
        chk("rst_busy_a", {31'd0, a_busy}, 32'd0);
        chk("rst_valid_b", {31'd0, b_vo}, 32'd0);
        chk("rst_ready_b", {31'd0, b_ready}, 32'd1);
        chk("rst_busy_b", {31'd0, b_busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", nvec, nerr);
        $fatal(1);
    end

    initial begin
        int n_seen;
        int g;
        reset_n = 1'b0;
        drive(0, '0, 1'b0, 1'b0);
        drive(1, '0, 1'b0, 1'b0);
        flush();
        repeat (3) @(negedge clk);
        check_reset_state();
        reset_n = 1'b1;
        @(negedge clk);

        // single vector, then a back-to-back burst of three that must stream without bubbles
        send(0, 32'h04030201, 1'b0);
        wait_drain();
        for (int i = 0; i < 3; i++) send(0, $urandom, 1'b0);
        wait_drain();

        // five pixels through a 2x2 frame, then mid-frame resync twice
        for (int i = 0; i < 5; i++) send(0, $urandom, 1'b0);
        send(0, $urandom, 1'b1);
        send(0, $urandom, 1'b1);
        send(0, $urandom, 1'b0);
        wait_drain();

        // asynchronous reset at the 7th sample of a pixel with another buffered
        send(0, $urandom, 1'b0);
        send(0, $urandom, 1'b0);
        n_seen = a_vo ? 1 : 0;
        g = 0;
        while (n_seen < 7 && g < 100) begin
            @(negedge clk);
            g++;
            if (a_vo) n_seen++;
        end
        if (n_seen < 7) timeout_fail("reset_sample7");
        #1 reset_n = 1'b0;
        flush();
        #1 check_reset_state();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(0, $urandom, 1'b0);
        wait_drain();

        // one-sample pixels: every sample carries all four framing flags
        for (int i = 0; i < 3; i++) send(1, $urandom, 1'b0);
        for (int i = 0; i < 15; i++) begin
            send(1, $urandom, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();

        // randomized traffic with occasional resync and idle gaps
        for (int i = 0; i < 40; i++) begin
            send(0, $urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 14)) @(negedge clk);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
